// File: rtl/apb_acc_master.sv
// APB initiator that runs one accelerator job: eight operand writes
// followed by eight result reads, with wait-state, slave-error and timeout
// handling. All outputs are registered.
module apb_acc_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      start,
  input  logic [127:0]              op_a,
  input  logic [127:0]              op_b,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err,
  output logic [255:0]              result,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_FIN
  } state_t;

  state_t        r_state;
  logic [3:0]    r_k;
  logic [9:0]    r_wait;
  logic [127:0]  r_op_a;
  logic [127:0]  r_op_b;

  logic [3:0]    w_kn;
  logic [9:0]    w_wait_inc;
  logic          w_finish;

  // Writes (k<8) and reads (k>=8) both map to word k[2:0]+1.
  function automatic logic [APB_ADDR_WIDTH-1:0] f_addr(input logic [3:0] k);
    logic [31:0] v_sum;
    v_sum = BASE_ADDR + ({29'd0, k[2:0]} + 32'd1) * 32'd4;
    return v_sum[APB_ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] f_wdata(input logic [3:0]   k,
                                          input logic [127:0] a,
                                          input logic [127:0] b);
    if (k[3])
      return '0;
    else if (!k[2])
      return a[{k[1:0], 5'd0} +: 32];
    else
      return b[{k[1:0], 5'd0} +: 32];
  endfunction

  // Next transfer index, next wait count and job-termination condition.
  always_comb begin
    w_kn       = r_k + 4'd1;
    w_wait_inc = r_wait + 10'd1;
    w_finish   = 1'b0;
    if (r_state == S_ACCESS) begin
      if (PREADY)
        w_finish = PSLVERR || (r_k == 4'hF);
      else
        w_finish = (w_wait_inc == 10'(TIMEOUT));
    end
  end

  // Job sequencer with registered APB and status outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_wait  <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= '0;
      result  <= '0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_a  <= op_a;
            r_op_b  <= op_b;
            err     <= '0;
            result  <= '0;
            r_k     <= '0;
            r_wait  <= '0;
            busy    <= 1'b1;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b1;
            PADDR   <= f_addr(4'd0);
            PWDATA  <= f_wdata(4'd0, op_a, op_b);
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY && !PSLVERR && r_k[3])
            result[{r_k[2:0], 5'd0} +: 32] <= PRDATA;
          if (PREADY && PSLVERR)
            err <= 2'b01;
          else if (!PREADY && w_finish)
            err <= 2'b10;
          if (w_finish) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            r_state <= S_FIN;
          end else if (PREADY) begin
            r_k     <= w_kn;
            r_wait  <= '0;
            PENABLE <= 1'b0;
            PWRITE  <= ~w_kn[3];
            PADDR   <= f_addr(w_kn);
            PWDATA  <= f_wdata(w_kn, r_op_a, r_op_b);
            r_state <= S_SETUP;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_acc_master.sv
// Directed bench for apb_acc_master with a small APB slave model whose read
// data is a fixed function of the address.
module tb_apb_acc_master;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic         start;
  logic [127:0] op_a, op_b;
  logic         busy, done;
  logic [1:0]   err;
  logic [255:0] result;
  logic [11:0]  PADDR;
  logic [31:0]  PWDATA;
  logic         PWRITE, PSEL, PENABLE;
  logic [31:0]  PRDATA;
  logic         PREADY, PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  // slave configuration
  int          sl_waits = 0;
  bit          sl_stuck = 0;
  bit          sl_err_en = 0;
  logic [11:0] sl_err_addr = 12'h00C;
  int          sl_cnt = 0;

  // transfer log and monitors
  logic [11:0] lg_addr[32];
  logic        lg_wr[32];
  logic [31:0] lg_data[32];
  int          log_n = 0;
  int          hold_bad = 0;
  int          done_cnt = 0;
  int          psel_cnt = 0;
  logic [11:0] su_addr;
  logic [31:0] su_data;
  logic        su_wr;

  apb_acc_master #(
    .APB_ADDR_WIDTH(12),
    .BASE_ADDR(0),
    .TIMEOUT(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .err(err), .result(result),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] rd_word(input logic [11:0] a);
    return {8'hA5, a[7:0], ~a[7:0], 8'h3C};
  endfunction

  // Slave response, updated mid-cycle.
  always @(negedge HCLK) begin
    if (PSEL && PENABLE) begin
      PREADY = !sl_stuck && (sl_cnt >= sl_waits);
      sl_cnt = sl_cnt + 1;
    end else begin
      PREADY = 1'b0;
      sl_cnt = 0;
    end
    PRDATA  = PWRITE ? 32'h0 : rd_word(PADDR);
    PSLVERR = PREADY && sl_err_en && !PWRITE && (PADDR == sl_err_addr);
  end

  // Bus monitor: completed transfers, stability during waits, pulse counts.
  always @(posedge HCLK) begin
    if (done) done_cnt = done_cnt + 1;
    if (PSEL) psel_cnt = psel_cnt + 1;
    if (PSEL && !PENABLE) begin
      su_addr = PADDR; su_data = PWDATA; su_wr = PWRITE;
    end
    if (PSEL && PENABLE) begin
      if (PADDR !== su_addr || PWDATA !== su_data || PWRITE !== su_wr)
        hold_bad = hold_bad + 1;
      if (PREADY && log_n < 32) begin
        lg_addr[log_n] = PADDR; lg_wr[log_n] = PWRITE; lg_data[log_n] = PWDATA;
        log_n = log_n + 1;
      end
    end
  end

  // Pulse start for one edge, then wait (bounded) for done; lat = cycle of done.
  task automatic run_job(input bit hold_start, input bit scramble, output int lat);
    logic [127:0] sa, sb;
    int cyc;
    sa = op_a; sb = op_b;
    @(negedge HCLK); start = 1'b1;
    @(posedge HCLK); #1;
    if (!hold_start) start = 1'b0;
    if (scramble) begin op_a = ~sa; op_b = ~sb; end
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(posedge HCLK); #1;
      cyc++;
    end
    lat = cyc;
    op_a = sa; op_b = sb;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; start = 1'b0;
    op_a = '0; op_b = '0;
    repeat (3) @(posedge HCLK);
    #1;
    n_cmp++;
    if ({busy, done, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %h required 0",
               {busy, done, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA});
    end
    n_cmp++;
    if (result !== '0) begin
      n_bad++; $display("FAIL reset_result: got %h required 0", result);
    end
    HRESET = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_basic();
    logic [31:0] wtab[8];
    logic [11:0] ea;
    logic [31:0] ed;
    int lat;
    wtab = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
             32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    op_a = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    op_b = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    sl_waits = 0; log_n = 0; hold_bad = 0;
    run_job(0, 0, lat);
    n_cmp++;
    if (lat !== 33) begin n_bad++; $display("FAIL basic_latency: got %0d required 33", lat); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b required 0", busy); end
    n_cmp++;
    if (err !== 2'b00) begin n_bad++; $display("FAIL basic_err: got %b required 00", err); end
    n_cmp++;
    if (log_n !== 16) begin n_bad++; $display("FAIL basic_xfer_count: got %0d required 16", log_n); end
    for (int k = 0; k < 16; k++) begin
      ea = 12'(((k % 8) + 1) * 4);
      ed = (k < 8) ? wtab[k] : 32'h0;
      n_cmp++;
      if (lg_addr[k] !== ea || lg_wr[k] !== (k < 8) || lg_data[k] !== ed) begin
        n_bad++;
        $display("FAIL basic_xfer%0d: got addr %h wr %b data %h required addr %h wr %b data %h",
                 k, lg_addr[k], lg_wr[k], lg_data[k], ea, (k < 8), ed);
      end
    end
    for (int j = 0; j < 8; j++) begin
      n_cmp++;
      if (result[32*j +: 32] !== rd_word(12'((j + 1) * 4))) begin
        n_bad++;
        $display("FAIL basic_result%0d: got %h required %h", j, result[32*j +: 32],
                 rd_word(12'((j + 1) * 4)));
      end
    end
    @(posedge HCLK); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b required 0", done); end
  endtask

  task automatic test_wait_states();
    int lat;
    sl_waits = 3; log_n = 0; hold_bad = 0;
    run_job(0, 1, lat);
    n_cmp++;
    if (lat !== 81) begin n_bad++; $display("FAIL wait_latency: got %0d required 81", lat); end
    n_cmp++;
    if (hold_bad !== 0) begin n_bad++; $display("FAIL wait_hold: got %0d changes required 0", hold_bad); end
    n_cmp++;
    if (lg_data[7] !== 32'h1F1E1D1C) begin
      n_bad++; $display("FAIL wait_latched_op: got %h required 1f1e1d1c", lg_data[7]);
    end
    n_cmp++;
    if (result[255:224] !== rd_word(12'h020)) begin
      n_bad++; $display("FAIL wait_result7: got %h required %h", result[255:224], rd_word(12'h020));
    end
    sl_waits = 0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_slave_error();
    int lat;
    sl_err_en = 1;
    run_job(0, 0, lat);
    n_cmp++;
    if (lat !== 23) begin n_bad++; $display("FAIL slverr_latency: got %0d required 23", lat); end
    n_cmp++;
    if (err !== 2'b01) begin n_bad++; $display("FAIL slverr_err: got %b required 01", err); end
    n_cmp++;
    if (result[63:0] !== {rd_word(12'h008), rd_word(12'h004)}) begin
      n_bad++; $display("FAIL slverr_low: got %h required %h", result[63:0],
                        {rd_word(12'h008), rd_word(12'h004)});
    end
    n_cmp++;
    if (result[255:64] !== '0) begin
      n_bad++; $display("FAIL slverr_high: got %h required 0", result[255:64]);
    end
    psel_cnt = 0;
    repeat (5) @(posedge HCLK);
    #1;
    n_cmp++;
    if (psel_cnt !== 0) begin n_bad++; $display("FAIL slverr_psel_after: got %0d required 0", psel_cnt); end
    n_cmp++;
    if (err !== 2'b01) begin n_bad++; $display("FAIL slverr_err_held: got %b required 01", err); end
    sl_err_en = 0;
  endtask

  task automatic test_timeout();
    int lat;
    sl_stuck = 1;
    run_job(0, 0, lat);
    n_cmp++;
    if (lat !== 6) begin n_bad++; $display("FAIL timeout_latency: got %0d required 6", lat); end
    n_cmp++;
    if (err !== 2'b10) begin n_bad++; $display("FAIL timeout_err: got %b required 10", err); end
    n_cmp++;
    if (PSEL !== 1'b0) begin n_bad++; $display("FAIL timeout_psel: got %b required 0", PSEL); end
    sl_stuck = 0;
    @(posedge HCLK); #1;
    run_job(0, 0, lat);
    n_cmp++;
    if (lat !== 33 || err !== 2'b00) begin
      n_bad++; $display("FAIL timeout_rerun: got lat %0d err %b required lat 33 err 00", lat, err);
    end
    n_cmp++;
    if (result[127:96] !== rd_word(12'h010)) begin
      n_bad++; $display("FAIL timeout_rerun_result3: got %h required %h", result[127:96], rd_word(12'h010));
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int cyc;
    @(posedge HCLK); #1;
    done_cnt = 0;
    run_job(1, 0, lat);
    n_cmp++;
    if (lat !== 33) begin n_bad++; $display("FAIL hold_latency: got %0d required 33", lat); end
    @(posedge HCLK); #1;
    n_cmp++;
    if (PSEL !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL hold_idle_gap: got psel %b busy %b required 0 0", PSEL, busy);
    end
    @(posedge HCLK); #1;
    start = 1'b0;
    n_cmp++;
    if (PSEL !== 1'b1 || busy !== 1'b1 || PADDR !== 12'h004) begin
      n_bad++; $display("FAIL hold_restart: got psel %b busy %b addr %h required 1 1 004",
                        PSEL, busy, PADDR);
    end
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(posedge HCLK); #1;
      cyc++;
    end
    @(posedge HCLK); #1;
    n_cmp++;
    if (cyc !== 33 || done_cnt !== 2) begin
      n_bad++; $display("FAIL hold_second_job: got lat %0d dones %0d required 33 2", cyc, done_cnt);
    end
  endtask

  task automatic test_reset_mid_job();
    int lat;
    @(negedge HCLK); start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    repeat (13) @(posedge HCLK);
    #1;
    n_cmp++;
    if (!(PSEL && PENABLE && PWRITE) || PADDR !== 12'h01C) begin
      n_bad++; $display("FAIL midrst_pre: got psel %b en %b wr %b addr %h required 1 1 1 01c",
                        PSEL, PENABLE, PWRITE, PADDR);
    end
    done_cnt = 0;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    n_cmp++;
    if ({busy, done, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, result} !== '0) begin
      n_bad++; $display("FAIL midrst_outputs: got psel %b en %b busy %b addr %h data %h required all 0",
                        PSEL, PENABLE, busy, PADDR, PWDATA);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    n_cmp++;
    if (done_cnt !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d required 0", done_cnt); end
    run_job(0, 0, lat);
    n_cmp++;
    if (lat !== 33 || err !== 2'b00 || result[223:192] !== rd_word(12'h01C)) begin
      n_bad++; $display("FAIL midrst_rerun: got lat %0d err %b r6 %h required 33 00 %h",
                        lat, err, result[223:192], rd_word(12'h01C));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_slave_error();
    test_timeout();
    test_start_ignored();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_acc_master.md
# apb_acc_master

APB initiator that runs one complete accelerator job over the peripheral bus: it writes two 16-byte operand vectors into the accelerator's APB register window, then reads back the sixteen 16-bit results. It sits on the accelerator's APB slave port, in place of software-driven accesses, for DMA-style offload and for self-checking benches. Transfers are strictly sequential, with wait-state, slave-error and timeout handling.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12: width of PADDR.
- BASE_ADDR, 0: byte base of the accelerator window. It is added to every generated address.
- TIMEOUT, 255: maximum number of ACCESS cycles with PREADY low before the job is aborted. Range 1..1023.

Ports:
- HCLK  in  1  clock; everything is on the rising edge.
- HRESET  in  1  reset. Synchronous, active-high.
- start  in  1  job request. Sampled only in IDLE.
- op_a  in  128  operand A. Byte i is op_a[8i+7:8i].
- op_b  in  128  operand B, same layout as op_a.
- busy  out  1  high from the cycle after start is accepted until the cycle done is high. done is not included.
- done  out  1  one-cycle pulse at job end, for both success and abort.
- err  out  2  00 = ok, 01 = PSLVERR seen, 10 = timeout. Held until the next accepted start.
- result  out  256  result element j is result[16j+15:16j].
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error. Sampled only on the completing ACCESS cycle.

## Operation
- FSM states: IDLE, SETUP, ACCESS, FIN.
- Transaction counter k runs 0..15, four bits.
- IDLE, start=1:
  - latch op_a and op_b into internal registers;
  - clear err; clear result to 0;
  - set k=0; go to SETUP.
- Write transactions, k=0..7:
  - PWRITE=1;
  - word address w=k+1;
  - PWDATA = op_a[32k+31:32k] for k<4;
  - PWDATA = op_b[32(k-4)+31:32(k-4)] for k>=4.
- Read transactions, k=8..15:
  - PWRITE=0; PWDATA=0;
  - word address w=k-7;
  - on completion, result[32(k-8)+31:32(k-8)] <= PRDATA. PRDATA[15:0] is element 2(k-8).
- Address: PADDR = BASE_ADDR + (w<<2), truncated to APB_ADDR_WIDTH. No wrap checking.
- SETUP: PSEL=1, PENABLE=0. Always advances to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, with PADDR, PWRITE and PWDATA held from SETUP. On PREADY=1:
  - if PSLVERR=1: err<=01, go to FIN. result keeps the words captured so far, and the erroring read's data is not stored;
  - else if k=15: go to FIN;
  - else: k<=k+1, go to SETUP. There is no idle cycle between transfers.
- ACCESS with PREADY=0: stay in ACCESS and increment the wait counter. If the counter reaches TIMEOUT, set err<=10 and go to FIN. The wait counter clears on entry to each SETUP.
- FIN: done=1, PSEL=0, PENABLE=0. Go to IDLE.
- In IDLE and FIN, PSEL and PENABLE are 0, and PADDR, PWDATA and PWRITE are 0.
- start while not in IDLE, including the FIN cycle, is ignored.
- Changes to op_a and op_b after acceptance have no effect on the running job.

## Timing
- All outputs are registered.
- Reset values: every output is 0, the FSM is in IDLE, and k, the wait counter and the operand registers are 0.
- HRESET asserted mid-job: the outputs above take their reset values at the next edge.
  - No done pulse is produced.
  - The bus is released immediately, even mid-ACCESS.
- Zero-wait job (PREADY always 1):
  - start sampled at edge 0;
  - SETUP of transfer 0 in cycle 1, ACCESS in cycle 2;
  - transfer k occupies cycles 2k+1 and 2k+2;
  - FIN/done in cycle 33, IDLE in cycle 34;
  - total latency is 33 cycles from start to done.
- Each wait state adds one cycle.
- Timeout: the abort occurs after TIMEOUT consecutive ACCESS cycles with PREADY low. done follows one cycle later.
- result words become valid the cycle after their ACCESS completes.
- The full result is stable from the done cycle until the next accepted start.

## Test plan
- **Basic job:** op_a=0x0F0E..0100, op_b=0x1F1E..1110, slave PREADY=1.
  - Writes go to PADDR 0x04..0x20 with PWDATA 0x03020100 first and 0x1F1E1D1C last.
  - Reads go to 0x04..0x20.
  - result equals the model output, done at cycle 33, err=00.
- **Wait states:** PREADY low for 3 cycles on every transfer.
  - Address, data and control are held stable throughout.
  - done arrives at cycle 33+16*3=81.
- **Slave error:** PSLVERR=1 on the read of 0x0C.
  - err=01, done pulses, no further PSEL.
  - result[63:0] is captured and result[255:64]=0.
- **Timeout:** TIMEOUT=4 with PREADY stuck at 0 on the first write.
  - err=10 and done pulse after 4 ACCESS cycles; PSEL drops.
  - The next start clears err and reruns the job correctly.
- **Start ignored:** start held high for the whole job.
  - Exactly one job runs.
  - The next job begins at the first IDLE cycle after FIN.
- **Reset mid-job:** HRESET asserted during ACCESS of transfer 6.
  - All outputs are 0 next cycle and there is no done pulse.
  - A start after reset release runs a full 33-cycle job.
